// File: rtl/fp_pkg.sv
// Shared types and format helpers for the floating-point add/subtract unit.
// Encoding helpers return 64-bit words; callers keep the low W bits.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CLS_ZERO,
    CLS_NORMAL,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  function automatic int unsigned fp_bias(input int unsigned exp_len);
    return (32'd1 << (exp_len - 1)) - 32'd1;
  endfunction

  function automatic logic [63:0] fp_inf(input int unsigned exp_len, input int unsigned man_len);
    return ((64'd1 << exp_len) - 64'd1) << man_len;
  endfunction

  function automatic logic [63:0] fp_canon_nan(input int unsigned exp_len, input int unsigned man_len);
    return fp_inf(exp_len, man_len) | (64'd1 << (man_len - 1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input yields WIDTH.
module fp_lzc #(
  parameter int unsigned WIDTH = 27,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [CW-1:0]    count
);

  // Ascending scan: the highest set bit is written last and wins.
  always_comb begin
    count = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_bits[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub_unit.sv
// Multi-cycle IEEE-style add/subtract with round-to-nearest-even, denormal
// flush-to-zero and valid/ready handshakes; one operation in flight.
module fp_addsub_unit
  import fp_pkg::*;
#(
  parameter int unsigned EXP_LEN      = 8,
  parameter int unsigned MANTISSA_LEN = 23
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   a,
  input  logic [EXP_LEN+MANTISSA_LEN:0]   b,
  input  logic                            op_sub,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [EXP_LEN+MANTISSA_LEN:0]   sum,
  output logic [3:0]                      flags,
  output logic                            out_valid,
  input  logic                            out_ready
);

  localparam int unsigned E         = EXP_LEN;
  localparam int unsigned M         = MANTISSA_LEN;
  localparam int unsigned W         = 1 + E + M;
  localparam int unsigned DW        = M + 5;
  localparam int unsigned XW        = E + 2;
  localparam int unsigned LZW       = M + 4;
  localparam int unsigned CW        = $clog2(LZW + 1);
  localparam int unsigned SHIFT_MAX = M + 3;
  localparam int unsigned EXP_MAX   = 2 * fp_bias(E) + 1;
  localparam logic [W-1:0] POS_INF   = W'(fp_inf(E, M));
  localparam logic [W-1:0] CANON_NAN = W'(fp_canon_nan(E, M));

  state_e                state_q, state_d;
  logic [W-1:0]          a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic [3:0]            res_flags_q, res_flags_d, flags_q, flags_d;
  logic                  special_q, special_d, l_sign_q, l_sign_d;
  logic                  eff_sub_q, eff_sub_d, out_valid_q, out_valid_d;
  logic signed [XW-1:0]  exp_q, exp_d;
  logic [DW-1:0]         man_q, man_d, s_man_q, s_man_d;

  function automatic fp_class_e classify(input logic [E-1:0] ex, input logic [M-1:0] fr);
    if (ex == '0) return CLS_ZERO;
    if (ex == '1) return (fr != '0) ? CLS_NAN : CLS_INF;
    return CLS_NORMAL;
  endfunction

  // Special-case resolution (UNPACK)
  fp_class_e    a_cls, b_cls;
  logic         sp_hit;
  logic [W-1:0] sp_val;
  logic [3:0]   sp_flags;

  always_comb begin
    a_cls    = classify(a_q[W-2:M], a_q[M-1:0]);
    b_cls    = classify(b_q[W-2:M], b_q[M-1:0]);
    sp_hit   = 1'b1;
    sp_val   = '0;
    sp_flags = '0;
    if (a_cls == CLS_NAN || b_cls == CLS_NAN) begin
      sp_val = CANON_NAN;
    end else if (a_cls == CLS_INF && b_cls == CLS_INF) begin
      sp_val = (a_q[W-1] != b_q[W-1]) ? CANON_NAN : a_q;
      sp_flags = (a_q[W-1] != b_q[W-1]) ? 4'b1000 : 4'b0000;
    end else if (a_cls == CLS_INF) begin
      sp_val = a_q;
    end else if (b_cls == CLS_INF) begin
      sp_val = b_q;
    end else if (a_cls == CLS_ZERO && b_cls == CLS_ZERO) begin
      sp_val = {a_q[W-1] & b_q[W-1], {(W-1){1'b0}}};
    end else if (a_cls == CLS_ZERO) begin
      sp_val = b_q;
    end else if (b_cls == CLS_ZERO) begin
      sp_val = a_q;
    end else begin
      sp_hit = 1'b0;
    end
  end

  // Alignment: operand L is the larger magnitude, ties go to A
  logic          a_ge;
  logic [W-1:0]  l_op;
  logic [E-1:0]  s_exp, exp_diff;
  logic [DW-1:0] s_man_full, s_sh, s_man_al;

  always_comb begin
    a_ge       = a_q[W-2:0] >= b_q[W-2:0];
    l_op       = a_ge ? a_q : b_q;
    s_exp      = a_ge ? b_q[W-2:M] : a_q[W-2:M];
    s_man_full = {2'b01, (a_ge ? b_q[M-1:0] : a_q[M-1:0]), 3'b000};
    exp_diff   = l_op[W-2:M] - s_exp;
    s_sh       = s_man_full >> exp_diff;
    if (32'(exp_diff) > SHIFT_MAX) s_man_al = DW'(1);
    else s_man_al = s_sh | DW'((s_sh << exp_diff) != s_man_full);
  end

  logic [DW-1:0]        add_res, norm_man;
  logic signed [XW-1:0] norm_exp, rnd_exp;
  logic [CW-1:0]        lz_count;
  logic                 norm_uflow, round_up, rnd_oflow;
  logic [M:0]           rnd;

  fp_lzc #(.WIDTH(LZW), .CW(CW)) u_lzc (
    .in_bits (man_q[DW-2:0]),
    .count   (lz_count)
  );

  // Rounding works on the fraction only: a carry out of it leaves a zero
  // fraction, which is exactly the renormalised mantissa 1.000...
  always_comb begin
    add_res = eff_sub_q ? (man_q - s_man_q) : (man_q + s_man_q);
    if (man_q[DW-1]) begin
      norm_man = {1'b0, man_q[DW-1:2], man_q[1] | man_q[0]};
      norm_exp = exp_q + XW'(1);
    end else begin
      norm_man = man_q << lz_count;
      norm_exp = exp_q - XW'(lz_count);
    end
    norm_uflow = norm_exp[XW-1] || (norm_exp == '0);
    round_up   = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
    rnd        = {1'b0, man_q[DW-3:3]} + (M+1)'(round_up);
    rnd_exp    = exp_q + XW'(rnd[M]);
    rnd_oflow  = rnd_exp >= XW'(EXP_MAX);
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    res_flags_d = res_flags_q;
    sum_d       = sum_q;
    flags_d     = flags_q;
    special_d   = special_q;
    l_sign_d    = l_sign_q;
    eff_sub_d   = eff_sub_q;
    out_valid_d = out_valid_q;
    exp_d       = exp_q;
    man_d       = man_q;
    s_man_d     = s_man_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        a_d     = a;
        b_d     = {b[W-1] ^ op_sub, b[W-2:0]};
        flags_d = '0;
        state_d = S_UNPACK;
      end
      S_UNPACK: begin
        special_d   = sp_hit;
        res_d       = sp_val;
        res_flags_d = sp_flags;
        state_d     = S_ALIGN;
      end
      S_ALIGN: begin
        l_sign_d  = l_op[W-1];
        eff_sub_d = a_q[W-1] ^ b_q[W-1];
        exp_d     = {2'b00, l_op[W-2:M]};
        man_d     = {2'b01, l_op[M-1:0], 3'b000};
        s_man_d   = s_man_al;
        state_d   = S_ADD;
      end
      S_ADD: begin
        if (!special_q) begin
          man_d = add_res;
          if (add_res == '0) begin
            special_d   = 1'b1;
            res_d       = '0;
            res_flags_d = '0;
          end
        end
        state_d = S_NORM;
      end
      S_NORM: begin
        if (!special_q) begin
          man_d = norm_man;
          exp_d = norm_exp;
          if (norm_uflow) begin
            special_d   = 1'b1;
            res_d       = {l_sign_q, {(W-1){1'b0}}};
            res_flags_d = 4'b0011;
          end
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (!special_q) begin
          if (rnd_oflow) begin
            res_d       = {l_sign_q, POS_INF[W-2:0]};
            res_flags_d = 4'b0101;
          end else begin
            res_d       = {l_sign_q, rnd_exp[E-1:0], rnd[M-1:0]};
            res_flags_d = {3'b000, |man_q[2:0]};
          end
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (!out_valid_q) begin
          sum_d       = res_q;
          flags_d     = res_flags_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      res_flags_q <= '0;
      sum_q       <= '0;
      flags_q     <= '0;
      special_q   <= 1'b0;
      l_sign_q    <= 1'b0;
      eff_sub_q   <= 1'b0;
      out_valid_q <= 1'b0;
      exp_q       <= '0;
      man_q       <= '0;
      s_man_q     <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      res_flags_q <= res_flags_d;
      sum_q       <= sum_d;
      flags_q     <= flags_d;
      special_q   <= special_d;
      l_sign_q    <= l_sign_d;
      eff_sub_q   <= eff_sub_d;
      out_valid_q <= out_valid_d;
      exp_q       <= exp_d;
      man_q       <= man_d;
      s_man_q     <= s_man_d;
    end
  end

  assign in_ready  = rst_n && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp_addsub_unit.sv
// Directed FP32 vectors for fp_addsub_unit plus backpressure and reset sequences.
module tb_fp_addsub_unit;

  logic        clk = 1'b0;
  logic        rst_n, op_sub, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic [3:0]  flags;

  always #5 clk = ~clk;

  fp_addsub_unit #(.EXP_LEN(8), .MANTISSA_LEN(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum       (sum),
    .flags     (flags),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] sum;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns the number of edges from the accept edge until out_valid is seen.
  task automatic launch(input logic [31:0] va, input logic [31:0] vb, input logic vop,
                        output int lat);
    int waitc = 0;
    a = va; b = vb; op_sub = vop; in_valid = 1'b1;
    while (!in_ready && waitc < 20) begin
      tick();
      waitc++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 32'(out_valid), 32'd0);
    check({name, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;

    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
    vecs[2]  = '{32'h3FC00000, 32'hBE800000, 1'b0, 32'h3FA00000, 4'b0000};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
    vecs[4]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
    vecs[6]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000};
    vecs[7]  = '{32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011};
    // Sign follows the larger-magnitude operand, so this flush is -0.
    vecs[8]  = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011};
    vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
    vecs[10] = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000};
    vecs[11] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
    vecs[12] = '{32'h00000000, 32'hC0400000, 1'b0, 32'hC0400000, 4'b0000};
    vecs[13] = '{32'h00000000, 32'h40400000, 1'b1, 32'hC0400000, 4'b0000};
    vecs[14] = '{32'h00400000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000};
    vecs[15] = '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 4'b0000};
    vecs[16] = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001};
    vecs[17] = '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 4'b0101};
    vecs[18] = '{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001};

    rst_n = 1'b0; a = '0; b = '0; op_sub = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", sum, 32'd0);
    check("reset_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;
    tick();
    check("release_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].op, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd6);
      check($sformatf("v%0d_sum", i), sum, vecs[i].sum);
      check($sformatf("v%0d_flags", i), 32'(flags), 32'(vecs[i].flags));
      handshake($sformatf("v%0d", i));
    end

    // Backpressure: result held, new requests ignored.
    launch(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, lat);
    check("bp_latency", 32'(lat), 32'd6);
    a = 32'h3F800000; b = 32'h3F800000;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c % 2) == 0;
      tick();
      check($sformatf("bp%0d_sum", c), sum, 32'h7F800000);
      check($sformatf("bp%0d_flags", c), 32'(flags), 32'h5);
      check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    handshake("bp");
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid || !in_ready) seen++;
    end
    check("bp_no_ghost_op", 32'(seen), 32'd0);

    // Reset during ALIGN abandons the operation.
    a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_in_ready_low", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    check("midrst_sum", sum, 32'd0);

    launch(vecs[2].a, vecs[2].b, vecs[2].op, lat);
    check("post_rst_latency", 32'(lat), 32'd6);
    check("post_rst_sum", sum, vecs[2].sum);
    handshake("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
